// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller.
package i2c_pkg;

  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_RESP
  } i2c_state_t;

  function automatic logic i2c_is_read(input i2c_cmd_t op);
    return (op == CMD_READ_ACK) || (op == CMD_READ_NAK);
  endfunction

endpackage

// File: rtl/i2c_sync_2ff.sv
// Two-flop synchronizer for an asynchronous pad level; resets to the idle-bus level (1).
module i2c_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C byte controller driving open-drain SCL/SDA enables.
// Optional I2C_CLK_STRETCH_EN: honour responder clock stretching on SCL release quarters.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [I2C_DATA_WIDTH-1:0] cmd_data,
  output logic                      resp_valid,
  output logic [I2C_DATA_WIDTH-1:0] resp_data,
  output logic                      resp_nak,
  output logic                      resp_err,
  output logic                      busy,
  output logic                      scl_oe,
  output logic                      sda_oe,
  input  logic                      scl_i,
  input  logic                      sda_i
);

  // states: IDLE wait cmd | START (re)start cond | BIT 8 data + ack | STOP stop cond | RESP 1-clk response

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_ACK  = BW'(I2C_DATA_WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(I2C_DATA_WIDTH - 1);

  logic scl_s;
  logic sda_s;

  i2c_sync_2ff u_sync_scl (.clk(clk), .rst(rst), .d_i(scl_i), .q_o(scl_s));
  i2c_sync_2ff u_sync_sda (.clk(clk), .rst(rst), .d_i(sda_i), .q_o(sda_s));

  i2c_state_t                state_q;
  i2c_cmd_t                  op_q;
  logic [1:0]                qtr_q;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic [BW-1:0]             bit_q;
  logic [I2C_DATA_WIDTH-1:0] tx_q;
  logic [I2C_DATA_WIDTH-1:0] rx_q;
  logic                      err_q;
  logic                      nak_q;
  logic                      cmd_ready_q;
  logic                      resp_valid_q;
  logic [I2C_DATA_WIDTH-1:0] resp_data_q;
  logic                      resp_nak_q;
  logic                      resp_err_q;
  logic                      busy_q;
  logic                      scl_oe_q;
  logic                      sda_oe_q;
  logic                      in_seq;
  logic                      scl_ok;
  logic                      tick;

`ifdef I2C_CLK_STRETCH_EN
  logic rel_qtr;
  // Quarters that begin by releasing SCL cannot end until the line is really high.
  assign rel_qtr = ((state_q == ST_START) && (qtr_q == 2'd1)) ||
                   ((state_q == ST_BIT)   && (qtr_q == 2'd2)) ||
                   ((state_q == ST_STOP)  && (qtr_q == 2'd1));
  assign scl_ok  = !rel_qtr || scl_s;
`else
  logic scl_unused;
  assign scl_unused = scl_s;
  assign scl_ok     = 1'b1;
`endif

  assign in_seq = (state_q == ST_START) || (state_q == ST_BIT) || (state_q == ST_STOP);
  assign tick   = in_seq && (cnt_q == CNT_LAST) && scl_ok;

  always_comb begin
    cnt_d = cnt_q;
    if (!in_seq || tick) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= CMD_START;
      qtr_q        <= 2'd0;
      cnt_q        <= '0;
      bit_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      err_q        <= 1'b0;
      nak_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_nak_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      scl_oe_q     <= 1'b0;
      sda_oe_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= i2c_cmd_t'(cmd_op);
            tx_q        <= cmd_data;
            cmd_ready_q <= 1'b0;
            qtr_q       <= 2'd0;
            bit_q       <= '0;
            err_q       <= 1'b0;
            nak_q       <= 1'b0;
            case (cmd_op)
              CMD_START: begin
                state_q  <= ST_START;
                sda_oe_q <= 1'b0;
              end
              CMD_STOP: begin
                if (busy_q) begin
                  state_q  <= ST_STOP;
                  sda_oe_q <= 1'b1;
                end else begin
                  state_q <= ST_RESP;
                  err_q   <= 1'b1;
                end
              end
              CMD_WRITE: begin
                if (busy_q) begin
                  state_q  <= ST_BIT;
                  scl_oe_q <= 1'b1;
                  sda_oe_q <= ~cmd_data[I2C_DATA_WIDTH-1];
                end else begin
                  state_q <= ST_RESP;
                  err_q   <= 1'b1;
                end
              end
              CMD_READ_ACK, CMD_READ_NAK: begin
                if (busy_q) begin
                  state_q  <= ST_BIT;
                  scl_oe_q <= 1'b1;
                  sda_oe_q <= 1'b0;
                end else begin
                  state_q <= ST_RESP;
                  err_q   <= 1'b1;
                end
              end
              default: begin
                state_q <= ST_RESP;
                err_q   <= 1'b1;
              end
            endcase
          end
        end

        ST_START: begin
          if (tick) begin
            qtr_q <= qtr_q + 1'b1;
            case (qtr_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd1: sda_oe_q <= 1'b1;
              2'd2: scl_oe_q <= 1'b1;
              default: begin
                busy_q  <= 1'b1;
                state_q <= ST_RESP;
              end
            endcase
          end
        end

        ST_BIT: begin
          if (tick) begin
            qtr_q <= qtr_q + 1'b1;
            case (qtr_q)
              2'd0: ;
              2'd1: scl_oe_q <= 1'b0;
              2'd2: begin
                if (bit_q < BIT_ACK) begin
                  rx_q <= {rx_q[I2C_DATA_WIDTH-2:0], sda_s};
                end else begin
                  nak_q <= (op_q == CMD_WRITE) && sda_s;
                end
              end
              default: begin
                scl_oe_q <= 1'b1;
                tx_q     <= {tx_q[I2C_DATA_WIDTH-2:0], 1'b0};
                if (bit_q == BIT_ACK) begin
                  state_q <= ST_RESP;
                end else begin
                  bit_q <= bit_q + 1'b1;
                  // After the last data bit the master owns SDA only to ACK a read.
                  if (bit_q == BIT_LAST) begin
                    sda_oe_q <= (op_q == CMD_READ_ACK);
                  end else begin
                    sda_oe_q <= (op_q == CMD_WRITE) && !tx_q[I2C_DATA_WIDTH-2];
                  end
                end
              end
            endcase
          end
        end

        ST_STOP: begin
          if (tick) begin
            qtr_q <= qtr_q + 1'b1;
            case (qtr_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd1: sda_oe_q <= 1'b0;
              2'd2: ;
              default: begin
                busy_q  <= 1'b0;
                state_q <= ST_RESP;
              end
            endcase
          end
        end

        ST_RESP: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
          resp_nak_q   <= nak_q;
          resp_data_q  <= (!err_q && i2c_is_read(op_q)) ? rx_q : '0;
          cmd_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_nak   = resp_nak_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural I2C responder on a wired-AND bus.
module tb_i2c_master_ctrl;
  import i2c_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int LAT_SS   = 4 * CLK_DIV + 1;
  localparam int LAT_BYTE = 36 * CLK_DIV + 1;
  localparam logic [6:0] RSP_ADDR = 7'h22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, resp_valid, resp_nak, resp_err, busy, scl_oe, sda_oe;
  logic [7:0] resp_data;
  logic       tb_scl_low = 1'b0;
  logic       rsp_sda_low = 1'b0;
  logic       scl_line, sda_line;

  assign scl_line = ~(scl_oe | tb_scl_low);
  assign sda_line = ~(sda_oe | rsp_sda_low);

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_nak(resp_nak), .resp_err(resp_err),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_i(scl_line), .sda_i(sda_line)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder state
  logic       pscl = 1'b1, psda = 1'b1, smp_scl, smp_sda;
  logic       r_active = 1'b0, r_first = 1'b0, r_tx = 1'b0, r_addr_ok = 1'b0;
  logic       r_ack_smp = 1'b0;
  int         r_bcnt = 0;
  logic [7:0] r_shift = 8'h00;
  logic [7:0] rd_byte = 8'h3C;
  logic [6:0] cap_addr = 7'h00;
  logic       cap_rw = 1'b0;
  logic [7:0] cap_data = 8'h00;
  int         nstart = 0;
  int         nstop = 0;

  always @(negedge clk) begin
    smp_scl = scl_line;
    smp_sda = sda_line;
    if (pscl && smp_scl && psda && !smp_sda) begin
      nstart++;
      r_active = 1'b1; r_first = 1'b1; r_tx = 1'b0; r_addr_ok = 1'b0;
      r_bcnt = 0; rsp_sda_low = 1'b0;
    end else if (pscl && smp_scl && !psda && smp_sda) begin
      nstop++;
      r_active = 1'b0; rsp_sda_low = 1'b0;
    end else if (r_active) begin
      if (!pscl && smp_scl) begin
        if (r_bcnt < 8) r_shift = {r_shift[6:0], smp_sda};
        else r_ack_smp = smp_sda;
        r_bcnt++;
      end else if (pscl && !smp_scl) begin
        if (r_bcnt == 8) begin
          if (!r_tx) begin
            if (r_first) begin
              cap_addr  = r_shift[7:1];
              cap_rw    = r_shift[0];
              r_addr_ok = (r_shift[7:1] == RSP_ADDR);
            end else if (r_addr_ok) begin
              cap_data = r_shift;
            end
            rsp_sda_low = r_addr_ok;
          end else begin
            rsp_sda_low = 1'b0;
          end
        end else if (r_bcnt == 9) begin
          r_bcnt = 0;
          rsp_sda_low = 1'b0;
          if (!r_tx) begin
            if (r_first) begin
              r_first = 1'b0;
              if (r_addr_ok && cap_rw) begin
                r_tx = 1'b1;
                rsp_sda_low = ~rd_byte[7];
              end
            end
          end else if (!r_ack_smp) begin
            rsp_sda_low = ~rd_byte[7];
          end else begin
            r_tx = 1'b0;
          end
        end else if (r_bcnt >= 1 && r_tx) begin
          rsp_sda_low = ~rd_byte[7 - r_bcnt];
        end
      end
    end
    pscl = smp_scl;
    psda = smp_sda;
  end

  // Bus monitors
  logic mon_busy = 1'b0, busy_drop = 1'b0;
  logic mon_oe = 1'b0, oe_seen = 1'b0;
  always @(negedge clk) begin
    if (mon_busy && !busy) busy_drop = 1'b1;
    if (mon_oe && (scl_oe || sda_oe)) oe_seen = 1'b1;
  end

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, output int lat);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL timeout op=%0d: resp_valid never seen within 2000 clks", op);
    end
    lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, resp_valid, resp_nak, resp_err, busy, scl_oe, sda_oe} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 1000000",
               {cmd_ready, resp_valid, resp_nak, resp_err, busy, scl_oe, sda_oe});
    end
    checks++;
    if (resp_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", resp_data); end
  endtask

  task automatic test_illegal();
    int lat;
    logic [2:0] ops [4] = '{CMD_WRITE, CMD_STOP, CMD_READ_ACK, 3'd7};
    mon_oe = 1'b1; oe_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_cmd(ops[i], 8'h44, lat);
      checks++;
      if (resp_err !== 1'b1) begin errors++; $display("FAIL illegal_err op=%0d: got %b expected 1", ops[i], resp_err); end
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL illegal_lat op=%0d: got %0d expected 1", ops[i], lat); end
    end
    mon_oe = 1'b0;
    checks++;
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL illegal_bus: got oe activity %b expected 0", oe_seen); end
    checks++;
    if (resp_data !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_state: data=%h busy=%b expected 00/0", resp_data, busy);
    end
  endtask

  task automatic test_write();
    int lat;
    do_cmd(CMD_START, 8'h00, lat);
    checks++;
    if (lat !== LAT_SS || busy !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL wr_start: lat=%0d busy=%b err=%b expected %0d/1/0", lat, busy, resp_err, LAT_SS);
    end
    do_cmd(CMD_WRITE, 8'h44, lat);
    checks++;
    if (lat !== LAT_BYTE) begin errors++; $display("FAIL wr_addr_lat: got %0d expected %0d", lat, LAT_BYTE); end
    checks++;
    if (resp_nak !== 1'b0 || resp_err !== 1'b0 || resp_data !== 8'h00) begin
      errors++; $display("FAIL wr_addr_resp: nak=%b err=%b data=%h expected 0/0/00", resp_nak, resp_err, resp_data);
    end
    do_cmd(CMD_WRITE, 8'hA5, lat);
    checks++;
    if (lat !== LAT_BYTE || resp_nak !== 1'b0) begin
      errors++; $display("FAIL wr_data: lat=%0d nak=%b expected %0d/0", lat, resp_nak, LAT_BYTE);
    end
    do_cmd(CMD_STOP, 8'h00, lat);
    checks++;
    if (lat !== LAT_SS || busy !== 1'b0) begin
      errors++; $display("FAIL wr_stop: lat=%0d busy=%b expected %0d/0", lat, busy, LAT_SS);
    end
    checks++;
    if (cap_addr !== 7'h22 || cap_rw !== 1'b0 || cap_data !== 8'hA5) begin
      errors++; $display("FAIL wr_capture: addr=%h rw=%b data=%h expected 22/0/a5", cap_addr, cap_rw, cap_data);
    end
    checks++;
    if (scl_line !== 1'b1 || sda_line !== 1'b1) begin
      errors++; $display("FAIL wr_idle_bus: scl=%b sda=%b expected 1/1", scl_line, sda_line);
    end
  endtask

  task automatic test_read();
    int lat;
    int stops0;
    stops0 = nstop;
    do_cmd(CMD_START, 8'h00, lat);
    do_cmd(CMD_WRITE, 8'h45, lat);
    checks++;
    if (resp_nak !== 1'b0) begin errors++; $display("FAIL rd_addr_nak: got %b expected 0", resp_nak); end
    do_cmd(CMD_READ_NAK, 8'h00, lat);
    checks++;
    if (resp_data !== 8'h3C || resp_nak !== 1'b0 || lat !== LAT_BYTE) begin
      errors++; $display("FAIL rd_data: data=%h nak=%b lat=%0d expected 3c/0/%0d", resp_data, resp_nak, lat, LAT_BYTE);
    end
    checks++;
    if (r_ack_smp !== 1'b1) begin errors++; $display("FAIL rd_nak_bit: sda on 9th pulse %b expected 1", r_ack_smp); end
    do_cmd(CMD_STOP, 8'h00, lat);
    checks++;
    if (busy !== 1'b0 || nstop !== stops0 + 1) begin
      errors++; $display("FAIL rd_stop: busy=%b stops=%0d expected 0/%0d", busy, nstop, stops0 + 1);
    end
  endtask

  task automatic test_nak();
    int lat;
    do_cmd(CMD_START, 8'h00, lat);
    do_cmd(CMD_WRITE, 8'h90, lat);
    checks++;
    if (resp_nak !== 1'b1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL nak_addr: nak=%b err=%b expected 1/0", resp_nak, resp_err);
    end
    do_cmd(CMD_STOP, 8'h00, lat);
    checks++;
    if (lat !== LAT_SS || resp_err !== 1'b0 || resp_nak !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL nak_stop: lat=%0d err=%b nak=%b busy=%b expected %0d/0/0/0",
                         lat, resp_err, resp_nak, busy, LAT_SS);
    end
  endtask

  task automatic test_rep_start();
    int lat;
    int starts0;
    do_cmd(CMD_START, 8'h00, lat);
    busy_drop = 1'b0; mon_busy = 1'b1;
    do_cmd(CMD_WRITE, 8'h44, lat);
    starts0 = nstart;
    do_cmd(CMD_START, 8'h00, lat);
    checks++;
    if (nstart !== starts0 + 1 || resp_err !== 1'b0 || lat !== LAT_SS) begin
      errors++; $display("FAIL rep_start: starts=%0d err=%b lat=%0d expected %0d/0/%0d",
                         nstart, resp_err, lat, starts0 + 1, LAT_SS);
    end
    do_cmd(CMD_WRITE, 8'h45, lat);
    checks++;
    if (resp_nak !== 1'b0 || cap_rw !== 1'b1) begin
      errors++; $display("FAIL rep_addr: nak=%b rw=%b expected 0/1", resp_nak, cap_rw);
    end
    mon_busy = 1'b0;
    checks++;
    if (busy_drop !== 1'b0) begin errors++; $display("FAIL rep_busy: busy dropped %b expected 0", busy_drop); end
    do_cmd(CMD_READ_NAK, 8'h00, lat);
    do_cmd(CMD_STOP, 8'h00, lat);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rep_stop: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stops0;
    do_cmd(CMD_START, 8'h00, lat);
    stops0 = nstop;
    @(negedge clk);
    cmd_op = CMD_WRITE; cmd_data = 8'h44; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (69) @(posedge clk);
    #3;
    checks++;
    if (scl_oe !== 1'b1 || sda_oe !== 1'b1) begin
      errors++; $display("FAIL mid_pre: scl_oe=%b sda_oe=%b expected 1/1", scl_oe, sda_oe);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({scl_oe, sda_oe, cmd_ready, busy} !== 4'b0010) begin
      errors++; $display("FAIL mid_reset: scl_oe,sda_oe,ready,busy=%b expected 0010", {scl_oe, sda_oe, cmd_ready, busy});
    end
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (nstop !== stops0) begin errors++; $display("FAIL mid_nostop: stops=%0d expected %0d", nstop, stops0); end
    do_cmd(CMD_START, 8'h00, lat);
    do_cmd(CMD_STOP, 8'h00, lat);
    checks++;
    if (lat !== LAT_SS || busy !== 1'b0 || nstop !== stops0 + 1) begin
      errors++; $display("FAIL mid_recover: lat=%0d busy=%b stops=%0d expected %0d/0/%0d",
                         lat, busy, nstop, LAT_SS, stops0 + 1);
    end
  endtask

`ifdef I2C_CLK_STRETCH_EN
  task automatic test_stretch();
    int lat;
    do_cmd(CMD_START, 8'h00, lat);
    fork
      do_cmd(CMD_WRITE, 8'h44, lat);
      begin
        @(negedge clk);
        @(posedge clk);
        repeat (39) @(posedge clk);
        #2 tb_scl_low = 1'b1;
        repeat (22) @(posedge clk);
        #1 tb_scl_low = 1'b0;
      end
    join
    checks++;
    if (lat !== LAT_BYTE + 20) begin errors++; $display("FAIL stretch_lat: got %0d expected %0d", lat, LAT_BYTE + 20); end
    do_cmd(CMD_STOP, 8'h00, lat);
  endtask
`endif

  initial begin
    test_reset();
    test_illegal();
    test_write();
    test_read();
    test_nak();
    test_rep_start();
    test_reset_mid();
`ifdef I2C_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
